// File: rtl/wire_pipe_chain_if.sv
// -----------------------------------------------------------------------------
// wire_pipe_chain_if
//   Single-direction valid/ready word channel. It is used for both the
//   producer side and the consumer side of wire_pipe_chain.
//
//   Signals
//     valid  word on 'data' is meaningful this cycle (master -> slave)
//     data   WIDTH-bit word                           (master -> slave)
//     ready  slave takes the word this cycle          (slave  -> master)
//
//   A transfer happens on a rising clock edge where valid & ready are both 1.
// -----------------------------------------------------------------------------
interface wire_pipe_chain_if #(
    parameter int WIDTH = 8
) ();

    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface : wire_pipe_chain_if

// File: rtl/wire_pipe_chain.sv
// -----------------------------------------------------------------------------
// wire_pipe_chain
//   Elastic register chain. It carries a WIDTH-bit word through DEPTH stages
//   under valid/ready flow control. Empty stages never stall the data behind
//   them, so bubbles collapse toward the output. When the consumer is always
//   ready, the chain sustains one word per cycle. A full chain whose head is
//   being drained still accepts a new word in the same cycle.
//
//   Parameters
//     WIDTH      data word width in bits (>= 1)
//     DEPTH      number of register stages (>= 1)
//     RESET_VAL  value loaded into every data register at reset, and the
//                value shown on out_bus.data whenever the head stage is empty
//
//   Ports
//     clk            rising-edge clock
//     rst            asynchronous reset, active-high (async assert, sync release)
//     in_bus.valid   producer word valid                     (in)
//     in_bus.data    producer word                           (in)
//     in_bus.ready   chain accepts in_bus.data this cycle    (out)
//     out_bus.valid  stage DEPTH-1 holds a word              (out)
//     out_bus.data   word in stage DEPTH-1, else RESET_VAL   (out)
//     out_bus.ready  consumer takes out_bus.data this cycle  (in)
//     flush          drop every held word at the next edge   (in)
//     count          number of occupied stages, 0..DEPTH     (out)
//
//   Stage 0 is the input side and stage DEPTH-1 is the output side. There is
//   no FSM. The state is one valid bit plus one data register per stage.
// -----------------------------------------------------------------------------
module wire_pipe_chain #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    wire_pipe_chain_if.slave           in_bus,
    wire_pipe_chain_if.master          out_bus,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    // Per-stage state.
    logic [DEPTH-1:0] v;                // stage occupied
    logic [WIDTH-1:0] d     [DEPTH];    // stage word, meaningful only when v is set

    // Per-stage advance enable, and the word each stage would load.
    logic [DEPTH-1:0] mv;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];

    logic             accept;           // input handshake this cycle

    // ------------------------------------------------------------------
    // Advance chain, evaluated from the output back to the input.
    // A stage may load when it is empty or when its own content moves on.
    // This is what lets bubbles collapse, and what lets a full chain
    // pass through while the head is being drained.
    // ------------------------------------------------------------------
    assign mv[DEPTH-1] = !v[DEPTH-1] | out_bus.ready;

    for (genvar g = 0; g < DEPTH - 1; g++) begin : g_advance
        assign mv[g] = !v[g] | mv[g+1];
    end

    // In the flush cycle the input is refused, so an in-flight offer is never
    // half-taken. During reset it is refused as well.
    assign in_bus.ready = mv[0] & !flush & !rst;
    assign accept       = in_bus.valid & in_bus.ready;

    // ------------------------------------------------------------------
    // Source of each stage: stage 0 takes the producer, and every other
    // stage takes its upstream neighbour.
    // ------------------------------------------------------------------
    assign src_v[0] = accept;
    assign src_d[0] = in_bus.data;

    for (genvar g = 1; g < DEPTH; g++) begin : g_source
        assign src_v[g] = v[g-1];
        assign src_d[g] = d[g-1];
    end

    // ------------------------------------------------------------------
    // Stage registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data registers are reset together with the valid bits.
            // They are a handful of discrete flops, not a RAM, so the reset is
            // cheap, and the chain comes up in a fully known state.
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= RESET_VAL;
            end
        end else if (flush) begin
            // Valid bits are cleared. Data is left as-is because it is not
            // observable once its stage is empty.
            v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mv[i]) begin
                    // NOTE: non-blocking assignments make every stage sample
                    // its neighbour's pre-edge value, so the shift is
                    // independent of loop order.
                    v[i] <= src_v[i];
                    // Data only moves with a real word. An empty slot keeps
                    // its old contents, which saves toggling.
                    if (src_v[i]) begin
                        d[i] <= src_d[i];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    assign out_bus.valid = v[DEPTH-1];

    // Head data is masked when the head is empty, so a stale word never leaks.
    always_comb begin
        // NOTE: the default assignment comes first, so every path drives the
        // output and no latch is inferred.
        out_bus.data = RESET_VAL;
        if (v[DEPTH-1]) begin
            out_bus.data = d[DEPTH-1];
        end
    end

    // Occupancy is taken from registered state only, so it changes on the
    // edge after a transfer.
    assign count = CW'($countones(v));

endmodule : wire_pipe_chain

// File: tb/tb_wire_pipe_chain.sv
// -----------------------------------------------------------------------------
// tb_wire_pipe_chain
//   Directed bench for wire_pipe_chain. It has two instances:
//     dut1 : WIDTH=8,  DEPTH=4, RESET_VAL=8'hA5
//     dut2 : WIDTH=16, DEPTH=1, RESET_VAL=16'hC3C3, with its own reset
//   Inputs change 1 time unit after a rising edge. Outputs are sampled 1 unit
//   later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_wire_pipe_chain;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst;
    logic       rst2;
    logic       flush;
    logic       flush2;
    logic [2:0] count1;
    logic [0:0] count2;

    int n_checks = 0;
    int n_fail   = 0;

    wire_pipe_chain_if #(.WIDTH(8))  in1  ();
    wire_pipe_chain_if #(.WIDTH(8))  out1 ();
    wire_pipe_chain_if #(.WIDTH(16)) in2  ();
    wire_pipe_chain_if #(.WIDTH(16)) out2 ();

    wire_pipe_chain #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .in_bus  (in1),
        .out_bus (out1),
        .flush   (flush),
        .count   (count1)
    );

    wire_pipe_chain #(.WIDTH(16), .DEPTH(1), .RESET_VAL(16'hC3C3)) dut2 (
        .clk     (clk),
        .rst     (rst2),
        .in_bus  (in2),
        .out_bus (out2),
        .flush   (flush2),
        .count   (count2)
    );

    // The clock is gated so that reset can be checked with no clock running.
    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0; rst2 = 1'b0;
        flush = 1'b0; flush2 = 1'b0;
        in1.valid = 1'b0; in1.data = 8'h00; out1.ready = 1'b0;
        in2.valid = 1'b0; in2.data = 16'h0000; out2.ready = 1'b0;
        #1;
        rst = 1'b1; rst2 = 1'b1;
        #2;
        n_checks++; if (out1.valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out1.valid); end
        n_checks++; if (out1.data !== 8'hA5) begin n_fail++; $display("FAIL reset_out_data: got %h want a5", out1.data); end
        n_checks++; if (count1 !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count1); end
        n_checks++; if (in1.ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in1.ready); end
        n_checks++; if (out2.data !== 16'hC3C3) begin n_fail++; $display("FAIL reset_out_data_d1: got %h want c3c3", out2.data); end
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; rst2 = 1'b0;
        #1;
        n_checks++; if (in1.ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in1.ready); end
        n_checks++; if (in2.ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready_d1: got %b want 1", in2.ready); end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_latency();
        out1.ready = 1'b1;
        in1.valid  = 1'b1;
        in1.data   = 8'h11;
        #1;
        n_checks++; if (in1.ready !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready: got %b want 1", in1.ready); end
        tick();                     // edge 0: word accepted
        in1.valid = 1'b0;
        #1;
        n_checks++; if (count1 !== 3'd1) begin n_fail++; $display("FAIL lat_count: got %0d want 1", count1); end
        for (int e = 0; e <= 4; e++) begin
            logic       exp_v;
            logic [7:0] exp_d;
            exp_v = (e == 3);
            exp_d = exp_v ? 8'h11 : 8'hA5;
            n_checks++; if (out1.valid !== exp_v) begin n_fail++; $display("FAIL lat_valid_e%0d: got %b want %b", e, out1.valid, exp_v); end
            n_checks++; if (out1.data !== exp_d) begin n_fail++; $display("FAIL lat_data_e%0d: got %h want %h", e, out1.data, exp_d); end
            tick();
            #1;
        end
        n_checks++; if (count1 !== 3'd0) begin n_fail++; $display("FAIL lat_count_end: got %0d want 0", count1); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        int exp_next;
        int first;
        int last;
        exp_next = 0; first = -1; last = -1;
        out1.ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c < 16) begin
                in1.valid = 1'b1;
                in1.data  = 8'(c);
            end else begin
                in1.valid = 1'b0;
            end
            #1;
            if (c < 16) begin
                n_checks++; if (in1.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_c%0d: got %b want 1", c, in1.ready); end
            end
            if (out1.valid === 1'b1) begin
                n_checks++; if (out1.data !== 8'(exp_next)) begin n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", exp_next, out1.data, 8'(exp_next)); end
                exp_next++;
                if (first < 0) first = c;
                last = c;
            end
            tick();
        end
        n_checks++; if (exp_next !== 16) begin n_fail++; $display("FAIL b2b_words: got %0d want 16", exp_next); end
        n_checks++; if (last - first !== 15) begin n_fail++; $display("FAIL b2b_contiguous: got span %0d want 15", last - first); end
        n_checks++; if (first !== 4) begin n_fail++; $display("FAIL b2b_first_cycle: got %0d want 4", first); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        logic [7:0] exp_seq [5];
        int         idx;
        exp_seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        out1.ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in1.valid = 1'b1;
            in1.data  = 8'(k);
            #1;
            n_checks++; if (in1.ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept_%0d: got %b want 1", k, in1.ready); end
            tick();
        end
        in1.data = 8'h05;
        #1;
        n_checks++; if (in1.ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready: got %b want 0", in1.ready); end
        n_checks++; if (count1 !== 3'd4) begin n_fail++; $display("FAIL bp_full_count: got %0d want 4", count1); end
        n_checks++; if (out1.data !== 8'h01) begin n_fail++; $display("FAIL bp_head: got %h want 01", out1.data); end
        tick();                                 // hold edge: nothing may move
        n_checks++; if (count1 !== 3'd4) begin n_fail++; $display("FAIL bp_hold_count: got %0d want 4", count1); end
        out1.ready = 1'b1;
        #1;
        n_checks++; if (in1.ready !== 1'b1) begin n_fail++; $display("FAIL bp_passthru_in_ready: got %b want 1", in1.ready); end
        idx = 0;
        for (int j = 0; j < 8; j++) begin
            if (j < 5) begin
                n_checks++; if (out1.valid !== 1'b1 || out1.data !== exp_seq[j]) begin n_fail++; $display("FAIL bp_drain_%0d: got v=%b d=%h want v=1 d=%h", j, out1.valid, out1.data, exp_seq[j]); end
            end else begin
                n_checks++; if (out1.valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained_%0d: got v=%b want 0", j, out1.valid); end
            end
            tick();
            if (j == 0) begin
                in1.valid = 1'b0;
                #1;
                n_checks++; if (count1 !== 3'd4) begin n_fail++; $display("FAIL bp_passthru_count: got %0d want 4", count1); end
            end
            #1;
        end
        n_checks++; if (count1 !== 3'd0) begin n_fail++; $display("FAIL bp_count_end: got %0d want 0", count1); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_bubble_collapse();
        out1.ready = 1'b0;
        in1.valid  = 1'b1;
        in1.data   = 8'h21;
        tick();
        in1.valid = 1'b0;
        tick();
        tick();
        in1.valid = 1'b1;
        in1.data  = 8'h22;
        tick();
        in1.valid = 1'b0;
        repeat (3) tick();
        #1;
        n_checks++; if (count1 !== 3'd2) begin n_fail++; $display("FAIL bub_count: got %0d want 2", count1); end
        n_checks++; if (out1.valid !== 1'b1 || out1.data !== 8'h21) begin n_fail++; $display("FAIL bub_head: got v=%b d=%h want v=1 d=21", out1.valid, out1.data); end
        n_checks++; if (in1.ready !== 1'b1) begin n_fail++; $display("FAIL bub_in_ready: got %b want 1", in1.ready); end
        out1.ready = 1'b1;
        tick();
        n_checks++; if (out1.valid !== 1'b1 || out1.data !== 8'h22) begin n_fail++; $display("FAIL bub_second: got v=%b d=%h want v=1 d=22", out1.valid, out1.data); end
        tick();
        n_checks++; if (out1.valid !== 1'b0 || count1 !== 3'd0) begin n_fail++; $display("FAIL bub_empty: got v=%b cnt=%0d want v=0 cnt=0", out1.valid, count1); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush();
        out1.ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in1.valid = 1'b1;
            in1.data  = 8'h31 + 8'(k);
            tick();
        end
        n_checks++; if (count1 !== 3'd3) begin n_fail++; $display("FAIL fl_fill_count: got %0d want 3", count1); end
        flush     = 1'b1;
        in1.valid = 1'b1;
        in1.data  = 8'h34;
        #1;
        n_checks++; if (in1.ready !== 1'b0) begin n_fail++; $display("FAIL fl_in_ready: got %b want 0", in1.ready); end
        tick();
        flush     = 1'b0;
        in1.valid = 1'b0;
        #1;
        n_checks++; if (count1 !== 3'd0) begin n_fail++; $display("FAIL fl_count: got %0d want 0", count1); end
        n_checks++; if (out1.valid !== 1'b0) begin n_fail++; $display("FAIL fl_out_valid: got %b want 0", out1.valid); end
        n_checks++; if (out1.data !== 8'hA5) begin n_fail++; $display("FAIL fl_out_data: got %h want a5", out1.data); end
        out1.ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            n_checks++; if (out1.valid !== 1'b0) begin n_fail++; $display("FAIL fl_leak_%0d: got v=%b d=%h want v=0", j, out1.valid, out1.data); end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset_depth1();
        out2.ready = 1'b0;
        in2.valid  = 1'b1;
        in2.data   = 16'hBEEF;
        #1;
        n_checks++; if (in2.ready !== 1'b1) begin n_fail++; $display("FAIL d1_empty_in_ready: got %b want 1", in2.ready); end
        tick();
        in2.valid = 1'b0;
        #1;
        n_checks++; if (out2.valid !== 1'b1 || out2.data !== 16'hBEEF) begin n_fail++; $display("FAIL d1_full: got v=%b d=%h want v=1 d=beef", out2.valid, out2.data); end
        n_checks++; if (count2 !== 1'b1) begin n_fail++; $display("FAIL d1_count: got %0d want 1", count2); end
        n_checks++; if (in2.ready !== 1'b0) begin n_fail++; $display("FAIL d1_full_in_ready: got %b want 0", in2.ready); end
        out2.ready = 1'b1;
        #1;
        n_checks++; if (in2.ready !== 1'b1) begin n_fail++; $display("FAIL d1_passthru: got %b want 1", in2.ready); end
        out2.ready = 1'b0;
        #1;
        rst2 = 1'b1;                            // between edges
        #1;
        n_checks++; if (out2.valid !== 1'b0) begin n_fail++; $display("FAIL d1_rst_valid: got %b want 0", out2.valid); end
        n_checks++; if (out2.data !== 16'hC3C3) begin n_fail++; $display("FAIL d1_rst_data: got %h want c3c3", out2.data); end
        n_checks++; if (count2 !== 1'b0) begin n_fail++; $display("FAIL d1_rst_count: got %0d want 0", count2); end
        n_checks++; if (in2.ready !== 1'b0) begin n_fail++; $display("FAIL d1_rst_in_ready: got %b want 0", in2.ready); end
        @(negedge clk);
        rst2 = 1'b0;
        tick();
        n_checks++; if (out2.valid !== 1'b0 || in2.ready !== 1'b1) begin n_fail++; $display("FAIL d1_after_rst: got v=%b rdy=%b want v=0 rdy=1", out2.valid, in2.ready); end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_bubble_collapse();
        test_flush();
        test_async_reset_depth1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Backstop in case the run ever stops making progress.
    initial begin
        #50000;
        $display("FAIL timeout: got no completion want completion by t=50000");
        $fatal(1, "timeout");
    end

endmodule : tb_wire_pipe_chain
